// File: rtl/nios2_dbg_pkg.sv
// Shared constants for the debug-monitor OCI memory controller.
// FSM encoding and JTAG jdo field positions.
package nios2_dbg_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_JRD  = 2'd1;
  localparam logic [1:0] ST_CRD  = 2'd2;
  localparam logic [1:0] ST_CACK = 2'd3;

  localparam int JDO_WDATA_HI = 34;
  localparam int JDO_WDATA_LO = 3;
  localparam int JDO_ADDR_HI  = 25;
  localparam int JDO_ADDR_LO  = 18;
  localparam int JDO_RDREQ    = 17;

endpackage

// File: rtl/nios2_dbg_ocimem_ctrl_if.sv
// CPU-side Avalon-MM debug slave bundle for the OCI memory.
// master = CPU, slave = memory controller.
interface nios2_dbg_ocimem_ctrl_if #(
  parameter int ADDR_W = 8
) ();

  logic [ADDR_W-1:0] avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [31:0]       avs_writedata;
  logic [3:0]        avs_byteenable;
  logic              avs_debugaccess;
  logic [31:0]       avs_readdata;
  logic              avs_waitrequest;

  modport master (
    output avs_address,
    output avs_read,
    output avs_write,
    output avs_writedata,
    output avs_byteenable,
    output avs_debugaccess,
    input  avs_readdata,
    input  avs_waitrequest
  );

  modport slave (
    input  avs_address,
    input  avs_read,
    input  avs_write,
    input  avs_writedata,
    input  avs_byteenable,
    input  avs_debugaccess,
    output avs_readdata,
    output avs_waitrequest
  );

endinterface

// File: rtl/nios2_dbg_ocimem_ram.sv
// Single-port synchronous RAM, 32b words, byte enables.
// Read data appears one clock after the address.
module nios2_dbg_ocimem_ram #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [31:0]       wdata,
  output logic [31:0]       q
);

  logic [31:0] mem [2**ADDR_W];

  // Byte-lane write and registered read (old data on collision).
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    q <= mem[addr];
  end

endmodule

// File: rtl/nios2_dbg_ocimem_ctrl.sv
// OCI RAM controller: arbitrates JTAG host and CPU debug slave.
// JTAG write > JTAG read > CPU write > CPU read, checked in IDLE.
module nios2_dbg_ocimem_ctrl
  import nios2_dbg_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [37:0] jdo,
  input  logic        take_action_ocimem_a,
  input  logic        take_action_ocimem_b,
  input  logic        take_no_action_ocimem_a,
  output logic [31:0] MonDReg,
  output logic        wr_protect_hit,
  output logic        jtag_overrun,
  nios2_dbg_ocimem_ctrl_if.slave avs
);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [ADDR_W-1:0] mon_areg;
  logic              jwr_pend;
  logic              jrd_pend;
  logic [31:0]       jwr_data;

  logic              idle;
  logic              jwr_req;
  logic              jrd_set;
  logic [31:0]       jwr_data_now;
  logic              g_jwr;
  logic              g_jrd;
  logic              g_cwr;
  logic              g_crd;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_q;

  logic              unused_jdo;
  assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

  assign idle    = (state == ST_IDLE);
  assign jwr_req = jwr_pend | take_action_ocimem_b;
  assign jrd_set = take_no_action_ocimem_a
                 | (take_action_ocimem_a & jdo[JDO_RDREQ]);
  assign jwr_data_now = take_action_ocimem_b
                      ? jdo[JDO_WDATA_HI:JDO_WDATA_LO]
                      : jwr_data;

  assign g_jwr = idle & jwr_req;
  assign g_jrd = idle & ~jwr_req & jrd_pend;
  assign g_cwr = idle & ~jwr_req & ~jrd_pend & avs.avs_write;
  assign g_crd = idle & ~jwr_req & ~jrd_pend
               & ~avs.avs_write & avs.avs_read;

  assign avs.avs_waitrequest = (state != ST_CACK);

  // Steer the single RAM port to the granted requester.
  always_comb begin
    ram_addr  = mon_areg;
    ram_we    = 1'b0;
    ram_be    = 4'h0;
    ram_wdata = jwr_data_now;
    unique case (1'b1)
      g_jwr: begin
        ram_we = 1'b1;
        ram_be = 4'hF;
      end
      g_cwr: begin
        ram_addr  = avs.avs_address;
        ram_we    = avs.avs_debugaccess;
        ram_be    = avs.avs_byteenable;
        ram_wdata = avs.avs_writedata;
      end
      g_crd: ram_addr = avs.avs_address;
      default: ;
    endcase
  end

  // Next-state logic; a started CPU transfer always runs to CACK.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (g_jrd) state_nxt = ST_JRD;
        else if (g_cwr) state_nxt = ST_CACK;
        else if (g_crd) state_nxt = ST_CRD;
      end
      ST_JRD:  state_nxt = ST_IDLE;
      ST_CRD:  state_nxt = ST_CACK;
      ST_CACK: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Pending JTAG requests; a write pulse merges into a pending one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      jwr_pend <= 1'b0;
      jrd_pend <= 1'b0;
      jwr_data <= '0;
    end else begin
      jwr_pend <= jwr_req & ~g_jwr;
      jrd_pend <= jrd_set | (jrd_pend & ~g_jrd);
      if (take_action_ocimem_b)
        jwr_data <= jdo[JDO_WDATA_HI:JDO_WDATA_LO];
    end
  end

  // Monitor address: explicit load beats auto-increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      mon_areg <= '0;
    else if (take_action_ocimem_a)
      mon_areg <= jdo[JDO_ADDR_LO +: ADDR_W];
    else if (g_jwr || state == ST_JRD)
      mon_areg <= mon_areg + 1'b1;
  end

  // Output registers: read data, protect pulse, sticky overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      MonDReg          <= '0;
      avs.avs_readdata <= '0;
      wr_protect_hit   <= 1'b0;
      jtag_overrun     <= 1'b0;
    end else begin
      if (state == ST_JRD) MonDReg <= ram_q;
      if (state == ST_CRD) avs.avs_readdata <= ram_q;
      wr_protect_hit <= g_cwr & ~avs.avs_debugaccess;
      if ((take_action_ocimem_b & jwr_pend)
          || (jrd_set & jrd_pend & ~g_jrd))
        jtag_overrun <= 1'b1;
    end
  end

  nios2_dbg_ocimem_ram #(
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .addr (ram_addr),
    .we   (ram_we),
    .be   (ram_be),
    .wdata(ram_wdata),
    .q    (ram_q)
  );

endmodule

// File: tb/tb_nios2_dbg_ocimem_ctrl.sv
// Directed bench for the OCI RAM controller.
// Inputs change #1 after rising edges; outputs sampled there too.
module tb_nios2_dbg_ocimem_ctrl;

  logic        clk;
  logic        reset;
  logic [37:0] jdo;
  logic        take_action_ocimem_a;
  logic        take_action_ocimem_b;
  logic        take_no_action_ocimem_a;
  logic [31:0] MonDReg;
  logic        wr_protect_hit;
  logic        jtag_overrun;

  int nvec;
  int nerr;

  nios2_dbg_ocimem_ctrl_if #(.ADDR_W(8)) avs ();

  nios2_dbg_ocimem_ctrl #(.ADDR_W(8)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .jdo                    (jdo),
    .take_action_ocimem_a   (take_action_ocimem_a),
    .take_action_ocimem_b   (take_action_ocimem_b),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .MonDReg                (MonDReg),
    .wr_protect_hit         (wr_protect_hit),
    .jtag_overrun           (jtag_overrun),
    .avs                    (avs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic jtag_addr(input logic [7:0] a, input logic rd);
    jdo = '0;
    jdo[25:18] = a;
    jdo[17] = rd;
    take_action_ocimem_a = 1'b1;
    cyc();
    take_action_ocimem_a = 1'b0;
  endtask

  task automatic jtag_wr(input logic [31:0] d);
    jdo = '0;
    jdo[34:3] = d;
    take_action_ocimem_b = 1'b1;
    cyc();
    take_action_ocimem_b = 1'b0;
  endtask

  task automatic jtag_stream();
    take_no_action_ocimem_a = 1'b1;
    cyc();
    take_no_action_ocimem_a = 1'b0;
  endtask

  task automatic cpu_wr(input logic [7:0] a, input logic [31:0] d,
                        input logic [3:0] be, input logic dbg,
                        output int edges, output logic hit);
    avs.avs_address = a;
    avs.avs_writedata = d;
    avs.avs_byteenable = be;
    avs.avs_debugaccess = dbg;
    avs.avs_write = 1'b1;
    edges = 99;
    hit = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (!avs.avs_waitrequest) begin
        edges = i;
        hit = wr_protect_hit;
        break;
      end
    end
    cyc();
    avs.avs_write = 1'b0;
  endtask

  task automatic cpu_rd(input logic [7:0] a, output logic [31:0] d,
                        output int edges);
    avs.avs_address = a;
    avs.avs_read = 1'b1;
    edges = 99;
    d = 'x;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (!avs.avs_waitrequest) begin
        edges = i;
        d = avs.avs_readdata;
        break;
      end
    end
    cyc();
    avs.avs_read = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc();
    cyc();
    nvec++;
    if (avs.avs_waitrequest !== 1'b1) begin
      nerr++;
      $display("FAIL rst_waitreq got %b want 1", avs.avs_waitrequest);
    end
    nvec++;
    if (MonDReg !== 32'h0 || avs.avs_readdata !== 32'h0) begin
      nerr++;
      $display("FAIL rst_data got %h/%h want 0/0", MonDReg, avs.avs_readdata);
    end
    nvec++;
    if (wr_protect_hit !== 1'b0 || jtag_overrun !== 1'b0) begin
      nerr++;
      $display("FAIL rst_flags got %b%b want 00", wr_protect_hit, jtag_overrun);
    end
    nvec++;
    if (dut.mon_areg !== 8'h00) begin
      nerr++;
      $display("FAIL rst_monareg got %h want 00", dut.mon_areg);
    end
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_jtag_rw();
    jtag_addr(8'h10, 1'b0);
    jtag_wr(32'hDEADBEEF);
    jtag_addr(8'h10, 1'b1);
    cyc();
    nvec++;
    if (MonDReg !== 32'h0) begin
      nerr++;
      $display("FAIL jrd_early got %h want 00000000", MonDReg);
    end
    cyc();
    nvec++;
    if (MonDReg !== 32'hDEADBEEF) begin
      nerr++;
      $display("FAIL jrd_data got %h want deadbeef", MonDReg);
    end
    nvec++;
    if (dut.mon_areg !== 8'h11) begin
      nerr++;
      $display("FAIL jrd_monareg got %h want 11", dut.mon_areg);
    end
  endtask

  task automatic test_wrap();
    jtag_addr(8'h00, 1'b0);
    jtag_wr(32'hCAFEF00D);
    jtag_addr(8'hFF, 1'b0);
    jtag_wr(32'h12345678);
    nvec++;
    if (dut.mon_areg !== 8'h00) begin
      nerr++;
      $display("FAIL wrap_inc got %h want 00", dut.mon_areg);
    end
    jtag_stream();
    cyc();
    cyc();
    nvec++;
    if (MonDReg !== 32'hCAFEF00D) begin
      nerr++;
      $display("FAIL wrap_rd got %h want cafef00d", MonDReg);
    end
    nvec++;
    if (dut.mon_areg !== 8'h01) begin
      nerr++;
      $display("FAIL wrap_monareg got %h want 01", dut.mon_areg);
    end
    jtag_addr(8'hFF, 1'b1);
    cyc();
    cyc();
    nvec++;
    if (MonDReg !== 32'h12345678) begin
      nerr++;
      $display("FAIL wrap_ff got %h want 12345678", MonDReg);
    end
  endtask

  task automatic test_cpu_bytes();
    int e;
    logic h;
    logic [31:0] d;
    jtag_addr(8'h20, 1'b0);
    jtag_wr(32'hFFFFFFFF);
    cpu_wr(8'h20, 32'hA5A5A5A5, 4'b0011, 1'b1, e, h);
    nvec++;
    if (e !== 1 || h !== 1'b0) begin
      nerr++;
      $display("FAIL cwr_ack got edges=%0d hit=%b want 1/0", e, h);
    end
    cpu_rd(8'h20, d, e);
    nvec++;
    if (e !== 2) begin
      nerr++;
      $display("FAIL crd_lat got %0d want 2", e);
    end
    nvec++;
    if (d !== 32'hFFFFA5A5) begin
      nerr++;
      $display("FAIL crd_data got %h want ffffa5a5", d);
    end
  endtask

  task automatic test_protect();
    int e;
    logic h;
    logic [31:0] d;
    cpu_wr(8'h20, 32'h00000000, 4'hF, 1'b0, e, h);
    nvec++;
    if (e !== 1 || h !== 1'b1) begin
      nerr++;
      $display("FAIL prot_hit got edges=%0d hit=%b want 1/1", e, h);
    end
    nvec++;
    if (wr_protect_hit !== 1'b0) begin
      nerr++;
      $display("FAIL prot_pulse got %b want 0", wr_protect_hit);
    end
    cpu_rd(8'h20, d, e);
    nvec++;
    if (d !== 32'hFFFFA5A5) begin
      nerr++;
      $display("FAIL prot_ram got %h want ffffa5a5", d);
    end
  endtask

  task automatic test_back_to_back();
    jtag_addr(8'h30, 1'b0);
    jdo = '0;
    jdo[34:3] = 32'h11111111;
    take_action_ocimem_b = 1'b1;
    avs.avs_address = 8'h31;
    avs.avs_writedata = 32'h22222222;
    avs.avs_byteenable = 4'hF;
    avs.avs_debugaccess = 1'b1;
    avs.avs_write = 1'b1;
    cyc();
    take_action_ocimem_b = 1'b0;
    nvec++;
    if (avs.avs_waitrequest !== 1'b1 || dut.mon_areg !== 8'h31) begin
      nerr++;
      $display("FAIL b2b_jfirst got wr=%b a=%h want 1/31",
               avs.avs_waitrequest, dut.mon_areg);
    end
    cyc();
    nvec++;
    if (avs.avs_waitrequest !== 1'b0) begin
      nerr++;
      $display("FAIL b2b_cack got %b want 0", avs.avs_waitrequest);
    end
    jdo[34:3] = 32'h33333333;
    take_action_ocimem_b = 1'b1;
    cyc();
    avs.avs_write = 1'b0;
    nvec++;
    if (jtag_overrun !== 1'b0 || dut.mon_areg !== 8'h31) begin
      nerr++;
      $display("FAIL b2b_pend got ovr=%b a=%h want 0/31",
               jtag_overrun, dut.mon_areg);
    end
    jdo[34:3] = 32'h44444444;
    cyc();
    take_action_ocimem_b = 1'b0;
    nvec++;
    if (jtag_overrun !== 1'b1) begin
      nerr++;
      $display("FAIL b2b_overrun got %b want 1", jtag_overrun);
    end
    nvec++;
    if (dut.mon_areg !== 8'h32) begin
      nerr++;
      $display("FAIL b2b_merge got %h want 32", dut.mon_areg);
    end
    jtag_addr(8'h30, 1'b1);
    cyc();
    cyc();
    nvec++;
    if (MonDReg !== 32'h11111111) begin
      nerr++;
      $display("FAIL b2b_rd30 got %h want 11111111", MonDReg);
    end
    jtag_stream();
    cyc();
    cyc();
    nvec++;
    if (MonDReg !== 32'h44444444) begin
      nerr++;
      $display("FAIL b2b_rd31 got %h want 44444444", MonDReg);
    end
  endtask

  task automatic test_reset_mid();
    avs.avs_address = 8'h20;
    avs.avs_read = 1'b1;
    cyc();
    nvec++;
    if (dut.state !== 2'd2) begin
      nerr++;
      $display("FAIL rmid_crd got %0d want 2", dut.state);
    end
    reset = 1'b1;
    #1;
    avs.avs_read = 1'b0;
    nvec++;
    if (dut.state !== 2'd0) begin
      nerr++;
      $display("FAIL rmid_state got %0d want 0", dut.state);
    end
    cyc();
    nvec++;
    if (avs.avs_waitrequest !== 1'b1) begin
      nerr++;
      $display("FAIL rmid_waitreq got %b want 1", avs.avs_waitrequest);
    end
    nvec++;
    if (MonDReg !== 32'h0 || jtag_overrun !== 1'b0) begin
      nerr++;
      $display("FAIL rmid_regs got %h/%b want 0/0", MonDReg, jtag_overrun);
    end
    reset = 1'b0;
    cyc();
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    reset = 1'b1;
    jdo = '0;
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    avs.avs_address = '0;
    avs.avs_read = 1'b0;
    avs.avs_write = 1'b0;
    avs.avs_writedata = '0;
    avs.avs_byteenable = '0;
    avs.avs_debugaccess = 1'b0;
    test_reset();
    test_jtag_rw();
    test_wrap();
    test_cpu_bytes();
    test_protect();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
